// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: widths, opcode encodings and FSM states.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_INC  = 4'd1;
    localparam logic [OP_W-1:0] OP_NEG  = 4'd2;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd3;
    localparam logic [OP_W-1:0] OP_PASS = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    function automatic logic isLegalOp(input logic [OP_W-1:0] op);
        return (op <= OP_PASS);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Command and response handshakes between the datapath control and the ALU sequencer.
interface alu_sequencer_if;
    import alu_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [CNT_W-1:0]  cmd_count;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_count, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_err
    );

endinterface

// File: rtl/alu_sequencer.sv
// Drives an external combinational ALU from flops, chains an op N times feeding the
// result back as operand A, and owns the architectural zero/negative flag register.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.slave    seqIf,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              flag_zero,
    output logic              flag_neg
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] aluA_q, aluA_d;
    logic [DATA_W-1:0] aluB_q, aluB_d;
    logic [OP_W-1:0]   aluOp_q, aluOp_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              err_q, err_d;
    logic              flagZero_q, flagZero_d;
    logic              flagNeg_q, flagNeg_d;

    always_comb begin
        state_d     = state_q;
        aluA_d      = aluA_q;
        aluB_d      = aluB_q;
        aluOp_d     = aluOp_q;
        remaining_d = remaining_q;
        result_d    = result_q;
        err_d       = err_q;
        flagZero_d  = flagZero_q;
        flagNeg_d   = flagNeg_q;

        case (state_q)
            IDLE: begin
                if (seqIf.cmd_valid) begin
                    state_d     = EXEC;
                    remaining_d = (seqIf.cmd_count == '0) ? CNT_W'(1) : seqIf.cmd_count;
                    // An illegal op spends its one EXEC cycle with the ALU left idle on pass.
                    if (isLegalOp(seqIf.cmd_op)) begin
                        aluA_d  = seqIf.cmd_a;
                        aluB_d  = seqIf.cmd_b;
                        aluOp_d = seqIf.cmd_op;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                    end
                end
            end
            EXEC: begin
                if (err_q) begin
                    state_d     = DONE;
                    remaining_d = '0;
                end else begin
                    result_d = alu_out;
                    if (aluOp_q != OP_PASS) begin
                        flagZero_d = alu_zero;
                        flagNeg_d  = alu_neg;
                    end
                    if (remaining_q > CNT_W'(1)) begin
                        aluA_d      = alu_out;
                        remaining_d = remaining_q - CNT_W'(1);
                    end else begin
                        state_d     = DONE;
                        aluOp_d     = OP_PASS;
                        remaining_d = '0;
                    end
                end
            end
            DONE: begin
                if (seqIf.rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aluA_q      <= '0;
            aluB_q      <= '0;
            aluOp_q     <= OP_PASS;
            remaining_q <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            flagZero_q  <= 1'b0;
            flagNeg_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aluA_q      <= aluA_d;
            aluB_q      <= aluB_d;
            aluOp_q     <= aluOp_d;
            remaining_q <= remaining_d;
            result_q    <= result_d;
            err_q       <= err_d;
            flagZero_q  <= flagZero_d;
            flagNeg_q   <= flagNeg_d;
        end
    end

    assign seqIf.cmd_ready  = (state_q == IDLE);
    assign seqIf.rsp_valid  = (state_q == DONE);
    assign seqIf.rsp_result = result_q;
    assign seqIf.rsp_err    = err_q;
    assign alu_a            = aluA_q;
    assign alu_b            = aluB_q;
    assign alu_op           = aluOp_q;
    assign flag_zero        = flagZero_q;
    assign flag_neg         = flagNeg_q;

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Command-driven controller for the team's 32-bit combinational ALU; it is the block that drives the ALU's operand and opcode inputs and consumes its result and zero/negative flags. It accepts one command at a time over a valid/ready handshake and can chain an operation N times, feeding each result back as operand A. It returns the final result and flags over a second valid/ready handshake. It sits between the datapath control logic and the ALU, and owns the architectural flag register.

## Interface
- OP_W, 4, opcode width
- DATA_W, 32, operand/result width
- CNT_W, 8, iteration count width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, synchronous and active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  OP_W  opcode (0 add, 1 inc, 2 negate, 3 sub, 4 pass)
- cmd_a, cmd_b  in  DATA_W  operands
- cmd_count  in  CNT_W  iterations; 0 is treated as 1
- alu_a, alu_b  out  DATA_W  registered ALU operands
- alu_op  out  OP_W  registered ALU opcode
- alu_out  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_op)
- alu_zero, alu_neg  in  1  ALU flags
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_result  out  DATA_W  final result
- rsp_err  out  1  illegal opcode
- flag_zero, flag_neg  out  1  architectural flag register

## Operation
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: load alu_a=cmd_a, alu_b=cmd_b, alu_op=cmd_op, remaining=max(cmd_count,1), then go to EXEC.
  - Opcodes 5–15: go to DONE with rsp_result=0 and rsp_err=1. The ALU is not driven and the flags are unchanged.
- EXEC: one cycle per iteration. At the clock edge, capture alu_out into rsp_result.
  - If alu_op≠4: flag_zero/flag_neg ← alu_zero/alu_neg.
  - If alu_op=4: the flags hold their previous value.
  - If remaining>1: alu_a ← alu_out, alu_b unchanged, remaining−1, stay in EXEC.
  - Otherwise go to DONE.
- DONE:
  - rsp_valid=1, with rsp_result and rsp_err stable.
  - On rsp_ready, go to IDLE and clear rsp_err.
  - While rsp_ready=0, all outputs hold.
- Outside EXEC, alu_op is driven as 4 (pass).
- Flags persist across commands; only EXEC with a non-pass op modifies them.
- Arithmetic is modulo 2^DATA_W. The sequencer does not re-derive flags; it trusts the ALU.

## Timing
- Reset values: cmd_ready=1, rsp_valid=0, rsp_result=0, rsp_err=0, alu_a=0, alu_b=0, alu_op=4, flag_zero=0, flag_neg=0, state=IDLE, remaining=0.
- Latency: command accepted at edge k.
  - rsp_valid rises after edge k+N, where N is the effective count (legal op).
  - Illegal op: rsp_valid rises after edge k+1.
- cmd_ready is high only in IDLE. There is a one-cycle minimum bubble between the rsp handshake and the next command acceptance.
- The ALU path must settle within one clk period; alu_* outputs are driven from flops only.
- Reset mid-operation (EXEC or DONE): on the next edge, all state returns to reset values. Any pending response is dropped and the flags are cleared.
- cmd_valid in DONE is ignored until the sequencer returns to IDLE. The command side must hold cmd_* stable until accepted.
- The count counter must not wrap: cmd_count=255 runs exactly 255 iterations.

## Structure
- Shared package alu_pkg:
  - opcode constants OP_ADD=0, OP_INC=1, OP_NEG=2, OP_SUB=3, OP_PASS=4
  - OP_W and DATA_W
  - state enum {IDLE, EXEC, DONE}
- No sub-module. The ALU stays a separate instance, wired to alu_* at the parent level.

## Test plan
- Reset: hold rst_n=0 for one edge -> cmd_ready=1, rsp_valid=0, alu_op=4, flags 0/0.
- Add: ADD a=5, b=7, count=1 -> rsp_valid after edge k+1, rsp_result=12, flag_zero=0, flag_neg=0.
- Flags and pass:
  - SUB a=3, b=3 -> result 0, flag_zero=1.
  - Then PASS a=0xFFFFFFFF -> result 0xFFFFFFFF, flag_zero still 1, flag_neg still 0.
- Chained increment: INC a=0xFFFFFFFE, count=3 -> alu_a sequence FFFFFFFE, FFFFFFFF, 0.
  - Result 1, flags 0/0.
  - rsp_valid after edge k+3; count=0 behaves as count=1.
- Illegal op: op=7 -> rsp_err=1, rsp_result=0, flags unchanged, rsp_valid after edge k+1, alu_op stays 4.
- Backpressure and reset:
  - rsp_ready=0 for 5 cycles -> rsp_* stable and cmd_ready=0 throughout.
  - Separately, rst_n=0 during EXEC of a count=200 command -> IDLE with reset values on the next edge.
